fetch_unit: RTL and testbench

Program-counter and instruction-fetch stage sitting directly upstream of the instruction ROM. It drives the ROM address, registers the returned DW-bit instruction into a one-entry fetch register for decode, and handles start-up at a selectable program entry point, stalls, absolute/relative branches with a one-cycle squash, halt detection and a saturating run-cycle counter.

---
 rtl/fetch_unit.sv | 87 ++++++++
 tb/tb_fetch_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC and instruction-fetch stage with start, stall, branch squash, halt and run-cycle counter
module fetch_unit #(
  parameter int              IW      = 16,
  parameter int              DW      = 9,
  parameter logic [DW-1:0]   HALT_OP = {DW{1'b1}}
) (
  input  logic          CLK,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic [IW-1:0] StartAddr,
  input  logic          Stall,
  input  logic          BranchEn,
  input  logic          BranchRel,
  input  logic [IW-1:0] Target,
  output logic [IW-1:0] InstAddress,
  input  logic [DW-1:0] InstIn,
  output logic [DW-1:0] InstOut,
  output logic [IW-1:0] InstPC,
  output logic          InstValid,
  output logic          Done,
  output logic [15:0]   CycleCount
);
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  state_t        state_q, state_d;
  logic [IW-1:0] pc_q, pc_d, ipc_q, ipc_d;
  logic [DW-1:0] inst_q, inst_d;
  logic          valid_q, valid_d, done_q, done_d;
  logic [15:0]   cnt_q, cnt_d;
  assign InstAddress = pc_q;
  assign InstOut     = inst_q;
  assign InstPC      = ipc_q;
  assign InstValid   = valid_q;
  assign Done        = done_q;
  assign CycleCount  = cnt_q;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    if (state_q == RUN) begin
      cnt_d = (&cnt_q) ? cnt_q : cnt_q + 16'd1;
      if (!Stall) begin
        if (valid_q && inst_q == HALT_OP) begin
          state_d = HALTED;
          done_d  = 1'b1;
          valid_d = 1'b0;
        end else if (valid_q && BranchEn) begin
          // the word returned by the ROM this cycle is dropped, leaving one bubble
          pc_d    = BranchRel ? ipc_q + Target : Target;
          valid_d = 1'b0;
        end else begin
          inst_d  = InstIn;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + IW'(1);
        end
      end
    end else if (Start) begin
      state_d = RUN;
      pc_d    = StartAddr;
      cnt_d   = 16'd0;
      done_d  = 1'b0;
    end
  end
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ipc_q   <= '0;
      inst_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test-plan scenarios plus randomized run against a behavioural fetch model
module tb_fetch_unit;
  localparam logic [8:0] HALT = 9'h1FF;
  logic        CLK = 1'b0;
  logic        Reset_n, Start, Stall, BranchEn, BranchRel;
  logic [15:0] StartAddr, Target, InstAddress, InstPC, CycleCount;
  logic [8:0]  InstIn, InstOut;
  logic        InstValid, Done;
  logic [8:0]  rom [0:65535];
  int checks = 0;
  int failures = 0;
  bit          m_run, m_valid, m_done;
  logic [15:0] m_pc, m_ipc, m_cnt;
  logic [8:0]  m_out;

  fetch_unit dut (
    .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr), .Stall(Stall),
    .BranchEn(BranchEn), .BranchRel(BranchRel), .Target(Target), .InstAddress(InstAddress),
    .InstIn(InstIn), .InstOut(InstOut), .InstPC(InstPC), .InstValid(InstValid),
    .Done(Done), .CycleCount(CycleCount)
  );

  assign InstIn = rom[InstAddress];
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_valid = 0; m_done = 0;
    m_pc = 0; m_ipc = 0; m_cnt = 0; m_out = 0;
  endtask

  // one clock edge of the fetch stage, described from the rules rather than a state machine
  task automatic model_edge();
    if (!Reset_n) begin
      model_reset();
    end else if (!m_run) begin
      if (Start) begin
        m_run = 1; m_pc = StartAddr; m_cnt = 0; m_done = 0;
      end
    end else begin
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      if (!Stall) begin
        if (m_valid && m_out == HALT) begin
          m_run = 0; m_done = 1; m_valid = 0;
        end else if (m_valid && BranchEn) begin
          m_pc = BranchRel ? 16'(m_ipc + Target) : Target;
          m_valid = 0;
        end else begin
          m_out = rom[m_pc]; m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 1;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".addr"},  32'(InstAddress), 32'(m_pc));
    check({tag, ".out"},   32'(InstOut),     32'(m_out));
    check({tag, ".ipc"},   32'(InstPC),      32'(m_ipc));
    check({tag, ".valid"}, 32'(InstValid),   32'(m_valid));
    check({tag, ".done"},  32'(Done),        32'(m_done));
    check({tag, ".cnt"},   32'(CycleCount),  32'(m_cnt));
  endtask

  task automatic step(input string tag);
    @(posedge CLK);
    model_edge();
    #1 compare_all(tag);
    @(negedge CLK);
  endtask

  task automatic do_start(input logic [15:0] addr);
    Start = 1; StartAddr = addr;
    step("start");
    Start = 0;
  endtask

  initial begin
    Reset_n = 0; Start = 0; StartAddr = 0; Stall = 0; BranchEn = 0; BranchRel = 0; Target = 0;
    for (int i = 0; i < 65536; i++) rom[i] = 9'($urandom_range(0, 510));
    model_reset();
    step("reset");
    Reset_n = 1;
    // sequential fetch to halt
    rom[16'h10] = 9'h001; rom[16'h11] = 9'h002; rom[16'h12] = 9'h003; rom[16'h13] = HALT;
    do_start(16'h0010);
    for (int i = 0; i < 4; i++) begin
      step("seq");
      check("seq_out", 32'(InstOut), (i == 3) ? 32'h1FF : 32'(i + 1));
      check("seq_pc", 32'(InstPC), 32'h10 + 32'(i));
    end
    step("halt");
    check("halt_done", 32'(Done), 1);
    check("halt_cnt", 32'(CycleCount), 5);
    repeat (2) step("halted");
    check("halted_cnt", 32'(CycleCount), 5);
    // stall for three cycles on 0x002
    do_start(16'h0010);
    repeat (2) step("pre_stall");
    Stall = 1;
    repeat (3) step("stall");
    check("stall_out", 32'(InstOut), 32'h002);
    check("stall_ipc", 32'(InstPC), 32'h11);
    check("stall_addr", 32'(InstAddress), 32'h12);
    check("stall_cnt", 32'(CycleCount), 5);
    Stall = 0;
    step("resume");
    check("resume_out", 32'(InstOut), 32'h003);
    repeat (2) step("stall_halt");
    check("stall_done", 32'(Done), 1);
    // relative then absolute branch
    rom[16'h13] = 9'h004; rom[16'h100] = 9'h011; rom[16'h101] = 9'h012; rom[16'h102] = HALT;
    do_start(16'h0010);
    repeat (3) step("pre_br");
    check("pre_br_ipc", 32'(InstPC), 32'h12);
    BranchEn = 1; BranchRel = 1; Target = 16'hFFFE;
    step("rel_br");
    check("rel_squash", 32'(InstValid), 0);
    BranchEn = 0;
    step("rel_tgt");
    check("rel_ipc", 32'(InstPC), 32'h10);
    check("rel_out", 32'(InstOut), 32'h001);
    BranchEn = 1; BranchRel = 0; Target = 16'h0100;
    step("abs_br");
    BranchEn = 0;
    step("abs_tgt");
    check("abs_ipc", 32'(InstPC), 32'h100);
    Start = 1; StartAddr = 16'h0055;
    step("start_in_run");
    Start = 0;
    check("start_in_run_ipc", 32'(InstPC), 32'h101);
    repeat (2) step("br_halt");
    check("br_done", 32'(Done), 1);
    // PC wrap
    rom[16'hFFFF] = 9'h005; rom[16'h0000] = HALT;
    do_start(16'hFFFF);
    step("wrap0");
    check("wrap_ipc0", 32'(InstPC), 32'hFFFF);
    step("wrap1");
    check("wrap_ipc1", 32'(InstPC), 32'h0000);
    step("wrap2");
    check("wrap_done", 32'(Done), 1);
    // restart from HALTED, then asynchronous reset mid-run
    for (int i = 0; i < 8; i++) rom[16'h20 + i] = 9'h030 + 9'(i);
    do_start(16'h0020);
    check("restart_done", 32'(Done), 0);
    check("restart_cnt", 32'(CycleCount), 0);
    check("restart_addr", 32'(InstAddress), 32'h20);
    repeat (5) step("pre_rst");
    check("pre_rst_addr", 32'(InstAddress), 32'h25);
    #2 Reset_n = 0;
    #1 model_reset();
    compare_all("async_rst");
    Start = 1; StartAddr = 16'h0077;
    repeat (2) step("in_rst");
    check("in_rst_addr", 32'(InstAddress), 0);
    Start = 0; Reset_n = 1;
    // randomized run
    for (int i = 0; i < 65536; i++) rom[i] = ($urandom_range(0, 31) == 0) ? HALT : 9'($urandom_range(0, 510));
    for (int n = 0; n < 4000; n++) begin
      Start     = ($urandom_range(0, 7) == 0);
      StartAddr = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
      Stall     = ($urandom_range(0, 3) == 0);
      BranchEn  = ($urandom_range(0, 5) == 0);
      BranchRel = 1'($urandom);
      Target    = 16'($urandom);
      if ($urandom_range(0, 699) == 0) begin
        Reset_n = 0;
        #1 model_reset();
        compare_all("rnd_rst");
      end else Reset_n = 1;
      step("rnd");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
